// File: rtl/apb_master.sv
// APB master bridge: takes one load/store request at a time from the core,
// decodes it onto one of four APB slaves and returns a one-cycle completion.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,

    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,

    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;

    logic        mapped;
    logic [1:0]  sel;
    logic        req_mapped;
    logic [1:0]  req_sel;

    logic        pready_sel;
    logic [31:0] prdata_sel;

    logic        done;
    logic        done_err;
    logic [31:0] done_rdata;

    logic [3:0]  psel_q, psel_nxt;
    logic        penable_nxt;

    // Slave n owns 0x1000_n000..0x1000_nFFF for n = 0..3
    always_comb begin
        req_mapped = (addr[31:16] == 16'h1000) && (addr[15:14] == 2'b00);
        req_sel    = addr[13:12];
    end

    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = '0;
        unique case (sel)
            2'd0: begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
            2'd1: begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
            2'd2: begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
            2'd3: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
        endcase
    end

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and completion decode; priority is unmapped, PREADY, timeout
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        unique case (state)
            IDLE: begin
                if (transfer) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = ACCESS;
                cnt_nxt   = '0;
            end
            ACCESS: begin
                if (!mapped) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (pready_sel) begin
                    done       = 1'b1;
                    done_rdata = PWRITE ? '0 : prdata_sel;
                end else if (cnt == CNT_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every APB output is a flop
    always_comb begin
        psel_nxt    = '0;
        penable_nxt = 1'b0;
        unique case (state_nxt)
            SETUP: begin
                if (req_mapped) psel_nxt = 4'b0001 << req_sel;
            end
            ACCESS: begin
                psel_nxt    = psel_q;
                penable_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            psel_q  <= '0;
            mapped  <= 1'b0;
            sel     <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            PENABLE <= penable_nxt;
            psel_q  <= psel_nxt;
            ready   <= done;
            if (state == IDLE && transfer) begin
                PADDR  <= addr;
                PWDATA <= wdata;
                PWRITE <= write;
                mapped <= req_mapped;
                sel    <= req_sel;
            end
            if (done) begin
                rdata <= done_rdata;
                err   <= done_err;
            end
        end
    end

    always_comb begin
        PSEL0 = psel_q[0];
        PSEL1 = psel_q[1];
        PSEL2 = psel_q[2];
        PSEL3 = psel_q[3];
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with four behavioural APB slave models.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    logic [3:0]  stall;
    logic        rdy0;
    logic [31:0] mem0 [16];
    logic [3:0]  psel;

    int n_checks = 0;
    int n_errors = 0;
    int psel_tot [4];
    int pen_tot = 0;
    int rdy_tot = 0;
    int b_psel [4];
    int b_pen, b_rdy;

    always #5 PCLK = ~PCLK;

    apb_master #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    // Slave 0: registered PREADY with a small memory; slaves 1..3: zero-wait unless stalled
    assign psel    = {PSEL3, PSEL2, PSEL1, PSEL0};
    assign PREADY0 = rdy0;
    assign PRDATA0 = mem0[PADDR[5:2]];
    assign PREADY1 = ~stall[1];
    assign PREADY2 = ~stall[2];
    assign PREADY3 = ~stall[3];
    assign PRDATA1 = 32'h1111_0000 | {16'h0, PADDR[15:0]};
    assign PRDATA2 = 32'h2222_0000 | {16'h0, PADDR[15:0]};
    assign PRDATA3 = 32'hDEAD_BEEF;

    always @(posedge PCLK) begin
        if (PRESET) rdy0 <= 1'b0;
        else        rdy0 <= PSEL0 && PENABLE && !rdy0;
        if (PSEL0 && PENABLE && rdy0 && PWRITE) mem0[PADDR[5:2]] <= PWDATA;
    end

    always @(posedge PCLK) begin
        #1;
        for (int i = 0; i < 4; i++) psel_tot[i] += int'(psel[i]);
        pen_tot += int'(PENABLE);
        rdy_tot += int'(ready);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) b_psel[i] = psel_tot[i];
        b_pen = pen_tot;
        b_rdy = rdy_tot;
    endtask

    // Caller is at a negedge; returns 1ns after the accepting edge (cycle 1)
    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
        transfer = 1'b1;
        write    = w;
        addr     = a;
        wdata    = d;
        @(posedge PCLK);
        #1 transfer = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int lat, output logic [31:0] rd, output logic er);
        int   n;
        logic got;
        n   = n0;
        got = 1'b0;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        while (n < 300 && !got) begin
            @(negedge PCLK);
            if (ready) begin
                got = 1'b1;
                lat = n;
                rd  = rdata;
                er  = err;
            end else begin
                n++;
            end
        end
        check("ready_seen", 32'(got), 32'd1);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
        @(negedge PCLK);
        snap();
        start(w, a, d);
        wait_done(1, lat, rd, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [31:0] unm [3];

        unm[0] = 32'h2000_0000;
        unm[1] = 32'h1000_4000;
        unm[2] = 32'h1001_0000;
        for (int i = 0; i < 16; i++) mem0[i] = '0;
        for (int i = 0; i < 4; i++) psel_tot[i] = 0;
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; stall = '0;

        repeat (3) @(negedge PCLK);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        PRESET = 1'b0;

        // Write then read slave 0 (registered PREADY)
        xfer(1'b1, 32'h1000_0008, 32'h0000_00A5, lat, rd, er);
        check("wr0_lat", 32'(lat), 32'd4);
        check("wr0_psel0", 32'(psel_tot[0] - b_psel[0]), 32'd3);
        check("wr0_pen", 32'(pen_tot - b_pen), 32'd2);
        check("wr0_other_psel", 32'(psel_tot[1] + psel_tot[2] + psel_tot[3] - b_psel[1] - b_psel[2] - b_psel[3]), 32'd0);
        check("wr0_pwrite", 32'(PWRITE), 32'd1);
        check("wr0_err", 32'(er), 32'd0);
        xfer(1'b0, 32'h1000_0008, 32'h0, lat, rd, er);
        check("rd0_lat", 32'(lat), 32'd4);
        check("rd0_rdata", rd, 32'h0000_00A5);
        check("rd0_pwrite", 32'(PWRITE), 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        check("rd0_ready_pulse", 32'(ready), 32'd0);
        check("rd0_rdata_hold", rdata, 32'h0000_00A5);

        // Write to a zero-wait slave returns rdata=0
        xfer(1'b1, 32'h1000_3000, 32'h1234_5678, lat, rd, er);
        check("wr3_lat", 32'(lat), 32'd3);
        check("wr3_rdata", rd, 32'h0);
        check("wr3_pwdata", PWDATA, 32'h1234_5678);

        // Unmapped addresses, including the decode boundaries
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, unm[i], 32'h0, lat, rd, er);
            check("unm_lat", 32'(lat), 32'd3);
            check("unm_err", 32'(er), 32'd1);
            check("unm_rdata", rd, 32'h0);
            check("unm_psel", 32'(psel_tot[0] + psel_tot[1] + psel_tot[2] + psel_tot[3] - b_psel[0] - b_psel[1] - b_psel[2] - b_psel[3]), 32'd0);
            check("unm_pen", 32'(pen_tot - b_pen), 32'd1);
        end

        // Decode to slave 3, zero wait
        xfer(1'b0, 32'h1000_3004, 32'h0, lat, rd, er);
        check("rd3_lat", 32'(lat), 32'd3);
        check("rd3_rdata", rd, 32'hDEAD_BEEF);
        check("rd3_err", 32'(er), 32'd0);
        check("rd3_psel3", 32'(psel_tot[3] - b_psel[3]), 32'd2);
        check("rd3_other_psel", 32'(psel_tot[0] + psel_tot[1] + psel_tot[2] - b_psel[0] - b_psel[1] - b_psel[2]), 32'd0);

        // Timeout on slave 1
        stall[1] = 1'b1;
        xfer(1'b0, 32'h1000_1000, 32'h0, lat, rd, er);
        check("to_lat", 32'(lat), 32'd18);
        check("to_pen", 32'(pen_tot - b_pen), 32'd16);
        check("to_err", 32'(er), 32'd1);
        check("to_rdata", rd, 32'h0);
        check("to_idle", 32'({PENABLE, psel}), 32'd0);
        stall[1] = 1'b0;

        // Back-to-back, plus a pulse during SETUP that must be dropped
        xfer(1'b0, 32'h1000_1004, 32'h0, lat, rd, er);
        check("b2b_a_rdata", rd, 32'h1111_1004);
        snap();
        start(1'b1, 32'h1000_3010, 32'h0000_0055);
        check("b2b_setup_psel", 32'(psel), 32'h8);
        check("b2b_setup_pen", 32'(PENABLE), 32'd0);
        check("b2b_paddr", PADDR, 32'h1000_3010);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000; wdata = 32'hFFFF_FFFF;
        @(posedge PCLK);
        #1 transfer = 1'b0;
        wait_done(2, lat, rd, er);
        check("b2b_b_lat", 32'(lat), 32'd3);
        check("b2b_b_rdata", rd, 32'h0);
        repeat (8) @(negedge PCLK);
        check("b2b_ready_count", 32'(rdy_tot - b_rdy), 32'd1);
        check("b2b_psel2", 32'(psel_tot[2] - b_psel[2]), 32'd0);
        check("b2b_paddr_hold", PADDR, 32'h1000_3010);

        // Reset during a stalled ACCESS
        stall[2] = 1'b1;
        @(negedge PCLK);
        snap();
        start(1'b0, 32'h1000_2000, 32'h0);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b1; transfer = 1'b1; addr = 32'h1000_3000;
        @(posedge PCLK);
        #1;
        check("rst_mid_psel", 32'(psel), 32'd0);
        check("rst_mid_pen", 32'(PENABLE), 32'd0);
        check("rst_mid_paddr", PADDR, 32'h0);
        PRESET = 1'b0; transfer = 1'b0;
        snap();
        repeat (20) @(negedge PCLK);
        check("rst_mid_no_ready", 32'(rdy_tot - b_rdy), 32'd0);
        check("rst_mid_no_psel", 32'(psel_tot[0] + psel_tot[1] + psel_tot[2] + psel_tot[3] - b_psel[0] - b_psel[1] - b_psel[2] - b_psel[3]), 32'd0);
        stall[2] = 1'b0;
        xfer(1'b0, 32'h1000_2004, 32'h0, lat, rd, er);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_rdata", rd, 32'h2222_2004);
        check("post_rst_err", 32'(er), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
